// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-port instruction memory between fetch and the loader,
// with a hold handshake for exclusive loader ownership. Define IMEM_BOUNDS_CHECK_EN for address checking.
module imem_arbiter #(
    parameter int DEPTH = 101,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_req,
    input  logic [31:0]   f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [31:0]   f_rdata,
    output logic          f_err,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [31:0]   l_addr,
    input  logic [31:0]   l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [31:0]   l_rdata,
    output logic          l_err,
    input  logic          l_hold,
    output logic          l_owned,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

    state_t        state;
    state_t        state_next;
    logic          last_loader;
    logic          f_win;
    logic          l_win;
    logic          f_bad;
    logic          l_bad;
    logic [AW-1:0] f_idx;
    logic [AW-1:0] l_idx;
    logic          rsp_f;
    logic          rsp_l;
    logic          rsp_err;
    logic          rsp_zero;

    assign f_idx = f_addr[AW+1:2];
    assign l_idx = l_addr[AW+1:2];

`ifdef IMEM_BOUNDS_CHECK_EN
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    assign f_bad = (f_addr[1:0] != 2'b00) || (f_addr[31:AW+2] != '0) || ({1'b0, f_idx} >= DEPTH_W);
    assign l_bad = (l_addr[1:0] != 2'b00) || (l_addr[31:AW+2] != '0) || ({1'b0, l_idx} >= DEPTH_W);
`else
    logic unused_addr_bits;

    assign f_bad = 1'b0;
    assign l_bad = 1'b0;
    assign unused_addr_bits = ^{f_addr[31:AW+2], f_addr[1:0], l_addr[31:AW+2], l_addr[1:0]};
`endif

    // Arbitration and ownership sequencing; the LOAD exit cycle grants nobody.
    always_comb begin
        state_next = state;
        f_win      = 1'b0;
        l_win      = 1'b0;
        case (state)
            RUN: begin
                if (f_req && l_req) begin
                    f_win = last_loader;
                    l_win = !last_loader;
                end else begin
                    f_win = f_req;
                    l_win = l_req;
                end
                if (l_hold) state_next = DRAIN;
            end
            DRAIN: begin
                state_next = l_hold ? LOAD : RUN;
            end
            LOAD: begin
                if (l_hold) l_win = l_req;
                else        state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign f_gnt   = f_win & rst_n;
    assign l_gnt   = l_win & rst_n;
    assign l_owned = (state == LOAD);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (f_gnt) begin
            mem_en   = !f_bad;
            mem_addr = f_idx;
        end else if (l_gnt) begin
            mem_en   = !l_bad;
            mem_we   = l_we & !l_bad;
            mem_addr = l_idx;
            if (l_we) mem_wdata = l_wdata;
        end
    end

    // Response bookkeeping is captured at the grant edge; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            last_loader <= 1'b1;
            rsp_f       <= 1'b0;
            rsp_l       <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_zero    <= 1'b0;
        end else begin
            state <= state_next;
            if (f_gnt)      last_loader <= 1'b0;
            else if (l_gnt) last_loader <= 1'b1;
            rsp_f    <= f_gnt;
            rsp_l    <= l_gnt;
            rsp_err  <= f_gnt ? f_bad : l_bad;
            rsp_zero <= f_gnt ? f_bad : (l_bad | l_we);
        end
    end

    assign f_rvalid = rsp_f;
    assign l_rvalid = rsp_l;
    assign f_err    = rsp_f & rsp_err;
    assign l_err    = rsp_l & rsp_err;
    assign f_rdata  = (rsp_f && !rsp_zero) ? mem_rdata : 32'h0;
    assign l_rdata  = (rsp_l && !rsp_zero) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed plus randomized stimulus for imem_arbiter, checked by a
// queue-based scoreboard against a cycle-level reference model of the arbitration rules.
module tb_imem_arbiter;

    localparam int DEPTH = 101;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          f_req;
    logic [31:0]   f_addr;
    logic          f_gnt;
    logic          f_rvalid;
    logic [31:0]   f_rdata;
    logic          f_err;
    logic          l_req;
    logic          l_we;
    logic [31:0]   l_addr;
    logic [31:0]   l_wdata;
    logic          l_gnt;
    logic          l_rvalid;
    logic [31:0]   l_rdata;
    logic          l_err;
    logic          l_hold;
    logic          l_owned;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    typedef struct {
        bit          f_req;
        logic [31:0] f_addr;
        bit          l_req;
        bit          l_we;
        logic [31:0] l_addr;
        logic [31:0] l_wdata;
        bit          l_hold;
    } stim_t;

    typedef struct {
        bit          is_loader;
        logic [31:0] data;
        bit          err;
        int          cyc;
    } rsp_t;

    rsp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          hold_run;
    bit          last_loader_m;
    bit          f_pending;
    bit          l_pending;
    stim_t       cur;
    logic [31:0] ref_mem [0:1023];
    logic [31:0] tb_mem  [0:1023];

    imem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_rdata(f_rdata), .f_err(f_err),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
        .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
        .l_hold(l_hold), .l_owned(l_owned),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    function automatic logic [31:0] mem_init(int i);
        return (i == 2) ? 32'h01095020 : (32'(i) * 32'h01010101) ^ 32'hA5A5_0000;
    endfunction

    // Single-port memory behind the arbiter: read data appears the cycle after mem_en.
    initial begin
        for (int i = 0; i < 1024; i++) tb_mem[i] = mem_init(i);
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) tb_mem[mem_addr] <= mem_wdata;
                else        mem_rdata <= tb_mem[mem_addr];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic bit addr_bad(logic [31:0] a);
`ifdef IMEM_BOUNDS_CHECK_EN
        return (a % 4 != 0) || (a / 4 >= DEPTH);
`else
        return 1'b0 & (|a);
`endif
    endfunction

    function automatic int word_index(logic [31:0] a);
        return int'((a >> 2) % 1024);
    endfunction

    function automatic stim_t make_stim(bit fr, logic [31:0] fa, bit lr, bit lw,
                                        logic [31:0] la, logic [31:0] ld, bit lh);
        stim_t s;
        s.f_req = fr; s.f_addr = fa; s.l_req = lr; s.l_we = lw;
        s.l_addr = la; s.l_wdata = ld; s.l_hold = lh;
        return s;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(DEPTH - 1)) << 2;
`ifdef IMEM_BOUNDS_CHECK_EN
        if ($urandom_range(7) == 0) a = $urandom();
`endif
        return a;
    endfunction

    // A requester left waiting keeps its request and payload unchanged.
    function automatic stim_t rand_stim();
        stim_t s;
        s = cur;
        if ($urandom_range(15) == 0) s.l_hold = !cur.l_hold;
        if (!f_pending) begin
            s.f_req  = ($urandom_range(3) != 0);
            s.f_addr = rand_addr();
        end
        if (!l_pending) begin
            s.l_req   = $urandom_range(1) != 0;
            s.l_we    = $urandom_range(1) != 0;
            s.l_addr  = rand_addr();
            s.l_wdata = $urandom();
        end
        return s;
    endfunction

    task automatic applyStimulus(input stim_t s);
        bit   fg, lg, fb, lb, exp_en, exp_we;
        int   fi, li;
        rsp_t r;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        f_req   = s.f_req;
        f_addr  = s.f_addr;
        l_req   = s.l_req;
        l_we    = s.l_we;
        l_addr  = s.l_addr;
        l_wdata = s.l_wdata;
        l_hold  = s.l_hold;
        cur     = s;
        @(negedge clk);
        fb = addr_bad(s.f_addr);
        lb = addr_bad(s.l_addr);
        fi = word_index(s.f_addr);
        li = word_index(s.l_addr);
        fg = 1'b0;
        lg = 1'b0;
        // hold_run counts consecutive earlier cycles with l_hold high: 0 arbitrates, 1 drains, 2+ owns.
        if (hold_run == 0) begin
            if (s.f_req && s.l_req) begin
                fg = last_loader_m;
                lg = !last_loader_m;
            end else begin
                fg = s.f_req;
                lg = s.l_req;
            end
        end else if (hold_run >= 2 && s.l_hold) begin
            lg = s.l_req;
        end
        exp_en = (fg && !fb) || (lg && !lb);
        exp_we = lg && s.l_we && !lb;
        checkOutput("f_gnt", 32'(f_gnt), 32'(fg));
        checkOutput("l_gnt", 32'(l_gnt), 32'(lg));
        checkOutput("l_owned", 32'(l_owned), 32'(hold_run >= 2));
        checkOutput("mem_en", 32'(mem_en), 32'(exp_en));
        checkOutput("mem_we", 32'(mem_we), 32'(exp_we));
        if (exp_en) checkOutput("mem_addr", 32'(mem_addr), 32'(fg ? fi : li));
        if (exp_we) checkOutput("mem_wdata", mem_wdata, s.l_wdata);
        if (fg) begin
            r.is_loader = 1'b0;
            r.data      = fb ? 32'h0 : ref_mem[fi];
            r.err       = fb;
            r.cyc       = cyc;
            sb_q.push_back(r);
        end
        if (lg) begin
            r.is_loader = 1'b1;
            r.data      = (lb || s.l_we) ? 32'h0 : ref_mem[li];
            r.err       = lb;
            r.cyc       = cyc;
            sb_q.push_back(r);
            if (s.l_we && !lb) ref_mem[li] = s.l_wdata;
        end
        f_pending = s.f_req && !fg;
        l_pending = s.l_req && !lg;
        if (fg)      last_loader_m = 1'b0;
        else if (lg) last_loader_m = 1'b1;
        hold_run = s.l_hold ? ((hold_run >= 2) ? 2 : hold_run + 1) : 0;
    endtask

    // Reset lands just after a sample point, so any grant from that cycle must never answer.
    task automatic applyReset();
        #1;
        rst_n   = 1'b0;
        f_req   = 1'b1;
        f_addr  = 32'h8;
        l_req   = 1'b1;
        l_we    = 1'b1;
        l_addr  = 32'h40;
        l_wdata = 32'hFFFF_FFFF;
        l_hold  = 1'b1;
        sb_q.delete();
        hold_run      = 0;
        last_loader_m = 1'b1;
        f_pending     = 1'b0;
        l_pending     = 1'b0;
        @(negedge clk);
        checkOutput("rst_f_gnt", 32'(f_gnt), 32'h0);
        checkOutput("rst_l_gnt", 32'(l_gnt), 32'h0);
        checkOutput("rst_f_err", 32'(f_err), 32'h0);
        checkOutput("rst_l_err", 32'(l_err), 32'h0);
        checkOutput("rst_l_owned", 32'(l_owned), 32'h0);
        checkOutput("rst_mem_en", 32'(mem_en), 32'h0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
        checkOutput("rst_f_rdata", f_rdata, 32'h0);
        checkOutput("rst_l_rdata", l_rdata, 32'h0);
        f_addr  = 32'h0;
        l_req   = 1'b0;
        l_we    = 1'b0;
        l_addr  = 32'h0;
        l_wdata = 32'h0;
        l_hold  = 1'b0;
        cur     = make_stim(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // Monitor: the oldest scoreboard entry is due exactly one cycle after its grant.
    initial begin
        rsp_t        r;
        bit          ef, el, ee;
        logic [31:0] ed;
        forever begin
            @(negedge clk);
            ef = 1'b0; el = 1'b0; ee = 1'b0; ed = 32'h0;
            if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                r  = sb_q.pop_front();
                ef = !r.is_loader;
                el = r.is_loader;
                ed = r.data;
                ee = r.err;
            end
            checkOutput("f_rvalid", 32'(f_rvalid), 32'(ef));
            checkOutput("l_rvalid", 32'(l_rvalid), 32'(el));
            if (ef) begin
                checkOutput("f_rdata", f_rdata, ed);
                checkOutput("f_err", 32'(f_err), 32'(ee));
            end
            if (el) begin
                checkOutput("l_rdata", l_rdata, ed);
                checkOutput("l_err", 32'(l_err), 32'(ee));
            end
        end
    end

    initial begin
        stim_t idle;
        rst_n = 1'b0;
        f_req = 1'b0; f_addr = 32'h0; l_req = 1'b0; l_we = 1'b0;
        l_addr = 32'h0; l_wdata = 32'h0; l_hold = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem_init(i);
        idle = make_stim(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        $display("[TB] reset and directed sequences");
        applyReset();
        repeat (4) applyStimulus(make_stim(1'b1, 32'h10, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0));
        applyStimulus(idle);
        applyStimulus(make_stim(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
        applyStimulus(idle);
        applyStimulus(make_stim(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h20080005, 1'b0));
        applyStimulus(make_stim(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
        applyStimulus(idle);

        repeat (3) applyStimulus(make_stim(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1));
        applyStimulus(make_stim(1'b1, 32'h4, 1'b1, 1'b1, 32'h80, 32'h12345678, 1'b1));
        applyStimulus(make_stim(1'b1, 32'h4, 1'b1, 1'b0, 32'h80, 32'h0, 1'b1));
        repeat (3) applyStimulus(make_stim(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
        applyStimulus(idle);

`ifdef IMEM_BOUNDS_CHECK_EN
        applyStimulus(make_stim(1'b1, 32'h194, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
        applyStimulus(make_stim(1'b1, 32'h6, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
        applyStimulus(make_stim(1'b0, 32'h0, 1'b1, 1'b1, 32'h1000, 32'hDEAD0001, 1'b0));
        applyStimulus(make_stim(1'b0, 32'h0, 1'b1, 1'b0, 32'h190, 32'h0, 1'b0));
        applyStimulus(idle);
`endif

        applyStimulus(make_stim(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
        applyReset();
        applyStimulus(idle);
        applyStimulus(idle);

        $display("[TB] randomized traffic");
        repeat (3000) applyStimulus(rand_stim());
        repeat (3) applyStimulus(idle);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single-port instruction memory between the CPU fetch stage and the program loader. Each cycle it grants at most one requester and drives the memory's word-indexed port. It returns read data or a write acknowledge one cycle later. It also sequences a hold handshake: the loader can take exclusive ownership of the memory, for example during program download, while fetch is stalled.

## Interface
- DEPTH, 101: number of 32-bit words in instruction memory.
- AW, 10: memory word-index width; the index is byte address bits [AW+1:2].
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- f_req  in  1  fetch read request.
- f_addr  in  32  fetch byte address.
- f_gnt  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  fetch response valid.
- f_rdata  out  32  fetch read data.
- f_err  out  1  fetch address error, qualified by f_rvalid.
- l_req  in  1  loader request.
- l_we  in  1  loader write (1) / read (0).
- l_addr  in  32  loader byte address.
- l_wdata  in  32  loader write data.
- l_gnt  out  1  loader request accepted this cycle.
- l_rvalid  out  1  loader response valid; also the write acknowledge.
- l_rdata  out  32  loader read data; 0 for writes.
- l_err  out  1  loader address error, qualified by l_rvalid.
- l_hold  in  1  loader requests exclusive ownership.
- l_owned  out  1  exclusive ownership is active.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory word index.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid the cycle after mem_en.

## Operation
- FSM states: RUN, DRAIN, LOAD. Reset state is RUN.
- RUN:
  - Round-robin between f_req and l_req. The last-winner register resets to "loader", so fetch wins the first conflict.
  - If only one requester is active, it wins.
  - l_hold=1 moves to DRAIN. The RUN→DRAIN cycle still arbitrates normally.
- DRAIN:
  - No grants are issued.
  - Waits one cycle so any outstanding response is returned, then moves to LOAD.
  - If l_hold drops during DRAIN, return to RUN.
- LOAD:
  - l_owned=1. Only the loader is granted; f_gnt=0.
  - l_hold=0 moves to RUN, with no grants in the exit cycle.
- Grant behaviour:
  - A grant is combinational from the request and state: gnt=1 in the cycle the request is accepted.
  - mem_en, mem_we, mem_addr and mem_wdata come from the winner in the same cycle.
  - mem_we=1 only for a loader write.
  - Fetch never writes.
- Responses:
  - Response registers capture the winner ID and error flag at the grant edge.
  - rdata is forwarded from mem_rdata in the response cycle, or forced to 0 on a write or error.
  - A requester holding req without a grant must keep its address and data stable.
- Reset values:
  - f_gnt, l_gnt, f_rvalid, l_rvalid, f_err, l_err, l_owned, mem_en and mem_we are 0.
  - rdata outputs, mem_addr and mem_wdata are 0.
  - Grants are forced 0 while rst_n=0.
- Reset asserted mid-transaction drops any pending response. No rvalid is issued for it.

## Timing
- Latency is 1 cycle, grant to rvalid.
- Throughput is one access per cycle total. Back-to-back grants to the same requester are allowed when the other is idle.
- Under continuous contention in RUN, grants alternate F, L, F, L.
- l_hold rise to l_owned=1 takes 2 cycles (RUN→DRAIN→LOAD).
- l_hold fall to the first fetch grant takes 1 cycle.
- A simultaneous l_hold rise and l_req in RUN: the request is arbitrated normally in that cycle.

## Configuration
- Macro IMEM_BOUNDS_CHECK_EN.
- Defined:
  - An address is out of range if addr[1:0]≠0, or addr[31:AW+2]≠0, or the word index is ≥ DEPTH.
  - An out-of-range request is still granted, but mem_en is held 0.
  - One cycle later it returns rvalid=1, err=1 and rdata=0.
- Undefined:
  - The index is addr[AW+1:2] with no checking.
  - f_err and l_err are tied 0.

## Test plan
- Reset:
  - Stimulus: assert rst_n=0 with f_req=1.
  - Required response: all outputs are 0 and no grant. After release, f_gnt=1 on the first cycle.
- Solo fetch:
  - Stimulus: f_addr=0x8, with the memory holding 0x01095020 at index 2.
  - Required response: f_gnt in cycle N, then f_rvalid=1 and f_rdata=0x01095020 in N+1.
- Contention:
  - Stimulus: f_req and l_req both held for 4 cycles.
  - Required response: grant order F, L, F, L, with responses one cycle later.
- Loader write:
  - Stimulus: a write of 0x20080005 to 0x40, then a fetch of 0x40.
  - Required response: mem_we=1 with mem_addr=16; l_rvalid=1 and l_rdata=0; the fetch returns 0x20080005.
- Hold:
  - Stimulus: raise l_hold while f_req is held.
  - Required response: at most 1 further fetch grant; l_owned=1 two cycles later; f_gnt=0 throughout LOAD; fetch resumes 1 cycle after l_hold falls.
- With IMEM_BOUNDS_CHECK_EN:
  - Stimulus: f_addr=0x194 (index 101), then f_addr=0x6.
  - Required response: for each, mem_en=0, then f_rvalid=1, f_err=1 and f_rdata=0.
